fault_recovery_ctrl: RTL

Sequencing controller placed downstream of fault_detector in the CPU core. When a fault is flagged on a valid instruction, it flushes the pipeline and redirects fetch back to the faulting PC to retry it. It escalates to a sticky halt after MAX_RETRY consecutive failed retries of the same instruction. It also keeps a saturating count of faults for status and debug.

---
 rtl/fault_recovery_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fault_recovery_ctrl.sv
// Fault recovery sequencer: flush, redirect to the faulting PC, retry, and halt after repeated failures.
// Optional 4-entry fault-PC log is enabled by defining FAULT_LOG_EN.
module fault_recovery_ctrl #(
    parameter int PC_W         = 32,
    parameter int MAX_RETRY    = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic             fault_detected,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_clear,
    output logic             stall,
    output logic             flush,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             halt,
    output logic [CNT_W-1:0] fault_count,
    output logic [3:0]       retry_cnt,
    output logic [2:0]       state
`ifdef FAULT_LOG_EN
    ,
    input  logic [1:0]       log_rd_idx,
    output logic [PC_W-1:0]  log_rd_pc,
    output logic [1:0]       log_wr_ptr
`endif
);

    typedef enum logic [2:0] {
        ST_NORMAL   = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_CHECK    = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [4:0] RETRY_LIMIT = 5'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  fault_pc_q, fault_pc_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;

    logic             sampled_fault;
    logic [CNT_W-1:0] fault_cnt_inc;
    logic [4:0]       retry_next;

    assign sampled_fault = instr_valid & fault_detected;
    // Saturate at all-ones rather than wrapping so debug never sees a small count after a storm.
    assign fault_cnt_inc = (fault_cnt_q == {CNT_W{1'b1}}) ? fault_cnt_q : fault_cnt_q + CNT_W'(1);
    assign retry_next    = {1'b0, retry_q} + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_NORMAL;
            fault_pc_q    <= '0;
            redirect_pc_q <= '0;
            fault_cnt_q   <= '0;
            retry_q       <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            fault_pc_q    <= fault_pc_d;
            redirect_pc_q <= redirect_pc_d;
            fault_cnt_q   <= fault_cnt_d;
            retry_q       <= retry_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fault_pc_d    = fault_pc_q;
        redirect_pc_d = redirect_pc_q;
        fault_cnt_d   = fault_cnt_q;
        retry_d       = retry_q;
        flush_cnt_d   = flush_cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (sampled_fault) begin
                    fault_pc_d  = pc;
                    retry_d     = '0;
                    fault_cnt_d = fault_cnt_inc;
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    // Latch the target now so redirect_pc is a plain register during REDIRECT.
                    redirect_pc_d = fault_pc_q;
                    state_d       = ST_REDIRECT;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (instr_valid) begin
                    if (!fault_detected) begin
                        retry_d = '0;
                        state_d = ST_NORMAL;
                    end else if (pc == fault_pc_q) begin
                        fault_cnt_d = fault_cnt_inc;
                        retry_d     = retry_next[3:0];
                        if (retry_next >= RETRY_LIMIT) begin
                            state_d = ST_HALT;
                        end else begin
                            flush_cnt_d = FLUSH_LOAD;
                            state_d     = ST_FLUSH;
                        end
                    end else begin
                        // A different PC faulting means the retry moved on; start a fresh recovery.
                        fault_pc_d  = pc;
                        retry_d     = '0;
                        fault_cnt_d = fault_cnt_inc;
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = ST_FLUSH;
                    end
                end
            end
            ST_HALT: begin
                if (halt_clear) begin
                    retry_d = '0;
                    state_d = ST_NORMAL;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    assign stall       = (state_q == ST_FLUSH) || (state_q == ST_REDIRECT) || (state_q == ST_HALT);
    assign flush       = (state_q == ST_FLUSH);
    assign redirect    = (state_q == ST_REDIRECT);
    assign halt        = (state_q == ST_HALT);
    assign redirect_pc = redirect_pc_q;
    assign fault_count = fault_cnt_q;
    assign retry_cnt   = retry_q;
    assign state       = state_q;

`ifdef FAULT_LOG_EN
    logic [PC_W-1:0] log_q [4];
    logic [1:0]      wr_ptr_q;
    logic            log_we;

    assign log_we = sampled_fault && ((state_q == ST_NORMAL) || (state_q == ST_CHECK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                log_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (log_we) begin
            log_q[wr_ptr_q] <= pc;
            wr_ptr_q        <= wr_ptr_q + 2'd1;
        end
    end

    assign log_rd_pc  = log_q[log_rd_idx];
    assign log_wr_ptr = wr_ptr_q;
`endif

endmodule
